// File: rtl/gbf_act_reader.sv
// GBF activation read path: fetches flag words and packed nonzero activation bytes,
// realigns the byte stream per block and hands one block at a time to the PEC side.
module gbf_act_reader #(
  parameter int unsigned PORT_DATAWIDTH = 96,
  parameter int unsigned BLOCK_DEPTH    = 32,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              Start,
  input  logic [15:0]                       CfgNumBlk,
  input  logic [ADDR_WIDTH-1:0]             CfgBaseFlg,
  input  logic [ADDR_WIDTH-1:0]             CfgBaseAct,
  output logic                              GBFFLGACT_EnRd,
  output logic [ADDR_WIDTH-1:0]             GBFFLGACT_AddrRd,
  input  logic [PORT_DATAWIDTH-1:0]         GBFFLGACT_DatRd,
  output logic                              GBFACT_EnRd,
  output logic [ADDR_WIDTH-1:0]             GBFACT_AddrRd,
  input  logic [PORT_DATAWIDTH-1:0]         GBFACT_DatRd,
  output logic [BLOCK_DEPTH-1:0]            PECMAC_FlgAct,
  output logic [DATA_WIDTH*BLOCK_DEPTH-1:0] PECMAC_Act,
  output logic                              Out_Val,
  input  logic                              Out_Rdy,
  output logic                              Busy,
  output logic                              Done
);

  localparam int unsigned FPW = PORT_DATAWIDTH / BLOCK_DEPTH;
  localparam int unsigned BPW = PORT_DATAWIDTH / DATA_WIDTH;
  localparam int unsigned STG = BLOCK_DEPTH + BPW;
  localparam int unsigned CW  = $clog2(STG + 1);
  localparam int unsigned KW  = (FPW > 1) ? $clog2(FPW) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_FLG, WT_FLG, POP, RD_ACT, WT_ACT, OUT, DONE
  } state_t;

  state_t                        state;
  logic [15:0]                   numBlk;
  logic [15:0]                   blkCnt;
  logic [ADDR_WIDTH-1:0]         flgAddr;
  logic [ADDR_WIDTH-1:0]         actAddr;
  logic [KW-1:0]                 k;
  logic [CW-1:0]                 stgCnt;
  logic [CW-1:0]                 pReg;
  logic [CW-1:0]                 popCnt;
  logic [PORT_DATAWIDTH-1:0]     flgWord;
  logic [BLOCK_DEPTH-1:0]        curBlk;
  logic [DATA_WIDTH-1:0]         stg       [STG];
  logic [DATA_WIDTH-1:0]         stgApp    [STG];
  logic [DATA_WIDTH-1:0]         stgPop    [STG];
  logic [DATA_WIDTH-1:0]         wordBytes [BPW];
  logic [DATA_WIDTH*BLOCK_DEPTH-1:0] actNext;

  // Current flag block (MSB-first within the word) and its population count.
  always_comb begin
    curBlk = '0;
    for (int unsigned i = 0; i < FPW; i++) begin
      if (32'(k) == i) curBlk = flgWord[PORT_DATAWIDTH-1-BLOCK_DEPTH*i -: BLOCK_DEPTH];
    end
    popCnt = '0;
    for (int unsigned j = 0; j < BLOCK_DEPTH; j++) begin
      popCnt = popCnt + CW'(curBlk[j]);
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < BPW; b++) begin
      wordBytes[b] = GBFACT_DatRd[PORT_DATAWIDTH-1-DATA_WIDTH*b -: DATA_WIDTH];
    end
  end

  // Append a fetched word right after the bytes already staged.
  always_comb begin
    for (int unsigned i = 0; i < STG; i++) begin
      stgApp[i] = stg[i];
      for (int unsigned b = 0; b < BPW; b++) begin
        if (32'(stgCnt) + b == i) stgApp[i] = wordBytes[b];
      end
    end
  end

  // Drop the bytes consumed by the accepted block; the tail fills with zero.
  always_comb begin
    for (int unsigned i = 0; i < STG; i++) stgPop[i] = '0;
    for (int unsigned p = 0; p <= BLOCK_DEPTH; p++) begin
      for (int unsigned i = 0; i < STG - p; i++) begin
        if (32'(pReg) == p) stgPop[i] = stg[i + p];
      end
    end
  end

  always_comb begin
    actNext = '0;
    for (int unsigned n = 0; n < BLOCK_DEPTH; n++) begin
      actNext[DATA_WIDTH*n +: DATA_WIDTH] = (n < 32'(popCnt)) ? stg[n] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      numBlk           <= '0;
      blkCnt           <= '0;
      flgAddr          <= '0;
      actAddr          <= '0;
      k                <= '0;
      stgCnt           <= '0;
      pReg             <= '0;
      flgWord          <= '0;
      for (int unsigned i = 0; i < STG; i++) stg[i] <= '0;
      GBFFLGACT_EnRd   <= 1'b0;
      GBFFLGACT_AddrRd <= '0;
      GBFACT_EnRd      <= 1'b0;
      GBFACT_AddrRd    <= '0;
      PECMAC_FlgAct    <= '0;
      PECMAC_Act       <= '0;
      Out_Val          <= 1'b0;
      Busy             <= 1'b0;
      Done             <= 1'b0;
    end else begin
      GBFFLGACT_EnRd <= 1'b0;
      GBFACT_EnRd    <= 1'b0;
      Done           <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            numBlk  <= CfgNumBlk;
            flgAddr <= CfgBaseFlg;
            actAddr <= CfgBaseAct;
            blkCnt  <= '0;
            k       <= '0;
            stgCnt  <= '0;
            if (CfgNumBlk == 16'd0) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state            <= RD_FLG;
              Busy             <= 1'b1;
              GBFFLGACT_EnRd   <= 1'b1;
              GBFFLGACT_AddrRd <= CfgBaseFlg;
            end
          end
        end
        RD_FLG: state <= WT_FLG;
        WT_FLG: begin
          flgWord <= GBFFLGACT_DatRd;
          state   <= POP;
        end
        POP: begin
          pReg <= popCnt;
          if (stgCnt >= popCnt) begin
            state         <= OUT;
            Out_Val       <= 1'b1;
            PECMAC_FlgAct <= curBlk;
            PECMAC_Act    <= actNext;
          end else begin
            state         <= RD_ACT;
            GBFACT_EnRd   <= 1'b1;
            GBFACT_AddrRd <= actAddr;
          end
        end
        RD_ACT: begin
          actAddr <= actAddr + ADDR_WIDTH'(1);
          state   <= WT_ACT;
        end
        WT_ACT: begin
          stg    <= stgApp;
          stgCnt <= stgCnt + CW'(BPW);
          state  <= POP;
        end
        OUT: begin
          if (Out_Rdy) begin
            Out_Val       <= 1'b0;
            PECMAC_FlgAct <= '0;
            PECMAC_Act    <= '0;
            stg           <= stgPop;
            stgCnt        <= stgCnt - pReg;
            blkCnt        <= blkCnt + 16'd1;
            if (blkCnt + 16'd1 == numBlk) begin
              state <= DONE;
              Done  <= 1'b1;
              Busy  <= 1'b0;
            end else if (k == KW'(FPW - 1)) begin
              k                <= '0;
              flgAddr          <= flgAddr + ADDR_WIDTH'(1);
              state            <= RD_FLG;
              GBFFLGACT_EnRd   <= 1'b1;
              GBFFLGACT_AddrRd <= flgAddr + ADDR_WIDTH'(1);
            end else begin
              k     <= k + KW'(1);
              state <= POP;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gbf_act_reader.md
Name: gbf_act_reader

Overview:
- Read-side counterpart of the GBF activation write path.
- Fetches activation flag words from GBFFLGACT and packed nonzero activation bytes from GBFACT.
- Re-aligns the byte stream on block boundaries and delivers one block at a time (BLOCK_DEPTH flags plus the matching nonzero activations) to a PEC-side consumer over a valid/ready handshake.
- Sits between the GBF SRAMs and the PEL activation distribution.

Parameters:
- PORT_DATAWIDTH, 96, GBF word width in bits. Must be a multiple of BLOCK_DEPTH and of DATA_WIDTH.
- BLOCK_DEPTH, 32, flags per block, i.e. the maximum number of activations per block.
- DATA_WIDTH, 8, activation width in bits.
- ADDR_WIDTH, 12, GBF word address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- Start  in  1  pulse; samples Cfg* and begins a pass
- CfgNumBlk  in  16  number of blocks to deliver; 0 means immediate Done
- CfgBaseFlg  in  ADDR_WIDTH  first GBFFLGACT word address
- CfgBaseAct  in  ADDR_WIDTH  first GBFACT word address
- GBFFLGACT_EnRd  out  1  flag read strobe
- GBFFLGACT_AddrRd  out  ADDR_WIDTH  flag read address
- GBFFLGACT_DatRd  in  PORT_DATAWIDTH  flag read data, valid the cycle after EnRd
- GBFACT_EnRd  out  1  activation read strobe
- GBFACT_AddrRd  out  ADDR_WIDTH  activation read address
- GBFACT_DatRd  in  PORT_DATAWIDTH  activation read data, valid the cycle after EnRd
- PECMAC_FlgAct  out  BLOCK_DEPTH  block flags, bit j = position j is nonzero
- PECMAC_Act  out  DATA_WIDTH*BLOCK_DEPTH  nonzero activation n at [DATA_WIDTH*n +: DATA_WIDTH]; unused upper lanes 0
- Out_Val  out  1  block valid
- Out_Rdy  in  1  consumer accepts
- Busy  out  1  high from the cycle after Start until Done
- Done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: all outputs 0, FSM in IDLE, staging count 0, address counters 0.
- FPW = PORT_DATAWIDTH/BLOCK_DEPTH flag blocks per word. BPW = PORT_DATAWIDTH/DATA_WIDTH bytes per word.
- Word layout is MSB-first:
  - Flag block k of a word is at [PORT_DATAWIDTH-1-BLOCK_DEPTH*k -: BLOCK_DEPTH].
  - Activation byte b of a word is at [PORT_DATAWIDTH-1-DATA_WIDTH*b -: DATA_WIDTH].
  - Activation bytes are packed contiguously across blocks and words. There is no per-block padding.
- Staging buffer: (BLOCK_DEPTH+BPW) bytes plus a byte count (StgCnt). A read word is appended after the existing bytes; StgCnt increases by BPW.
- FSM:
  - IDLE: on Start, latch config and set FlgAddr=CfgBaseFlg, ActAddr=CfgBaseAct, BlkCnt=0, sub-index k=0, StgCnt=0.
    - If CfgNumBlk==0, go to DONE.
    - Otherwise go to RD_FLG.
  - RD_FLG: assert GBFFLGACT_EnRd for 1 cycle at FlgAddr, then go to WT_FLG.
  - WT_FLG: capture the flag word, then go to POP.
  - POP: extract block k and compute P = popcount (0..BLOCK_DEPTH), registered.
    - If StgCnt >= P, go to OUT.
    - Otherwise go to RD_ACT.
  - RD_ACT: assert GBFACT_EnRd for 1 cycle at ActAddr, increment ActAddr, then go to WT_ACT.
  - WT_ACT: append the word, then go to POP-check. Loop RD_ACT until StgCnt >= P.
  - OUT: drive Out_Val=1 with FlgAct/Act stable.
    - On Out_Val&&Out_Rdy: consume P bytes (shift staging down, StgCnt -= P) and increment BlkCnt.
    - If BlkCnt+1==CfgNumBlk, go to DONE.
    - Else if k==FPW-1: k=0, FlgAddr+1, go to RD_FLG.
    - Else: k+1, go to POP.
  - DONE: Done=1 for 1 cycle, Busy=0, return to IDLE. Leftover staged bytes are discarded.
- Blocks with P=0 issue no GBFACT reads. PECMAC_Act is all zero for them.
- No read is ever issued while Out_Val is high and unaccepted, and outputs hold while stalled.
- Start while Busy is ignored. rst mid-pass aborts immediately to the reset state with no Done.
- Address counters wrap modulo 2^ADDR_WIDTH.
- At most one GBF read is outstanding at any time.

Test Plan:
- Defaults, CfgNumBlk=3, flag word 0 = {FFFFFFFF, 00000000, 0000000F}, act words hold bytes 01..24 (36 bytes):
  - Block 0 = 01..20, Act lane 0 = 01.
  - Block 1 is all-zero and issues no GBFACT_EnRd.
  - Block 2 Act = {24,23,22,21}.
  - Exactly 3 GBFACT reads and 1 GBFFLGACT read; Done 1 cycle after the 3rd accept.
- CfgNumBlk=4, block flags 00000007 each: flag reads at Base and Base+1. Act reads at ActAddr Base only (12 bytes cover the 12 needed).
- Out_Rdy held 0 for 10 cycles during OUT: Out_Val, FlgAct and Act stable; no EnRd asserted.
- CfgNumBlk=0: Done pulses 1 cycle after Start; no reads.
- rst asserted while in WT_ACT: next cycle all outputs 0, no Done. A new Start then restarts from CfgBaseFlg/CfgBaseAct.
- CfgBaseAct=FFF with 2 act reads: addresses FFF then 000.
